ifsram_r: RTL

- Reader counterpart to the ifmap SRAM store block.
- On a start pulse it reads FINAL_RD_NUM consecutive words from the ifmap SRAM, beginning at START_ADDR.
- It streams those words, in address order, to a downstream FIFO-style sink using a write/full_n handshake.
- It sits between the ifmap SRAM and the PE-feed path and reports busy/done to the controller.

---
 rtl/ifsram_r.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ifsram_r.sv
// rtl/ifsram_r.sv - ifmap SRAM reader streaming a fixed run of words to a FIFO-style sink
//
// Purpose:
//   On start_if_read (sampled in IDLE) reads FINAL_RD_NUM consecutive words
//   beginning at START_ADDR and streams them in address order through a
//   write/full_n handshake. A small credit scheme bounds the words in flight
//   plus the words buffered to the 2-entry output FIFO, so no read is ever dropped.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start_if_read         run request from the controller
//   if_read_busy          high while running
//   if_read_done          one-cycle pulse after the last transfer
//   cen_ifsram            SRAM chip enable (active-low)
//   wen_ifsram            SRAM write enable (active-low, tied off to read)
//   addr_ifsram           SRAM read address
//   q_ifsram              SRAM read data, valid one cycle after cen_ifsram=0
//   ifread_data_dout      stream data (head of output FIFO, 0 when empty)
//   ifread_write_dout     stream write strobe
//   ifread_full_n_din     sink not-full; transfer = write & full_n
module ifsram_r #(
    parameter int TBITS        = 64,
    parameter int ADDR_BITS    = 11,
    parameter int FINAL_RD_NUM = 192,
    parameter int START_ADDR   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_if_read,
    output logic                 if_read_busy,
    output logic                 if_read_done,
    output logic                 cen_ifsram,
    output logic                 wen_ifsram,
    output logic [ADDR_BITS-1:0] addr_ifsram,
    input  logic [TBITS-1:0]     q_ifsram,
    output logic [TBITS-1:0]     ifread_data_dout,
    output logic                 ifread_write_dout,
    input  logic                 ifread_full_n_din
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [11:0] NUM_WORDS = 12'(FINAL_RD_NUM);
    localparam logic [11:0] LAST_WORD = 12'(FINAL_RD_NUM - 1);

    state_t                 state_q;
    logic [11:0]            issue_cnt_q;
    logic [11:0]            xfer_cnt_q;
    logic                   inflight_q;   // a read was issued last cycle; q_ifsram is valid now
    logic [1:0]             fill_q;       // output FIFO occupancy (0..2)
    logic                   rd_ptr_q;
    logic                   wr_ptr_q;
    logic [TBITS-1:0]       mem_q [2];
    logic [ADDR_BITS-1:0]   addr_q;

    logic                   run;
    logic                   xfer;
    logic                   issue;
    logic [1:0]             credit;
    logic [ADDR_BITS-1:0]   issue_addr;
    logic [1:0]             fill_d;

    always_comb begin
        run        = (state_q == S_RUN);
        ifread_write_dout = run && (fill_q != 2'd0);
        xfer       = ifread_write_dout && ifread_full_n_din;
        credit     = fill_q + {1'b0, inflight_q};
        // A full credit window may still issue when a word leaves the FIFO this cycle.
        issue      = run && (issue_cnt_q < NUM_WORDS) && ((credit < 2'd2) || xfer);
        // Address arithmetic is done at ADDR_BITS so it wraps modulo the SRAM depth.
        issue_addr = ADDR_BITS'(START_ADDR) + ADDR_BITS'(issue_cnt_q);
        fill_d     = fill_q + {1'b0, inflight_q} - {1'b0, xfer};

        cen_ifsram       = ~issue;
        wen_ifsram       = 1'b1;
        addr_ifsram      = issue ? issue_addr : addr_q;
        ifread_data_dout = (fill_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
        if_read_busy     = run;
        if_read_done     = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            fill_q      <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            addr_q      <= '0;
        end else begin
            inflight_q <= issue;
            fill_q     <= fill_d;
            if (issue) begin
                issue_cnt_q <= issue_cnt_q + 12'd1;
                addr_q      <= issue_addr;
            end
            if (xfer) begin
                xfer_cnt_q <= xfer_cnt_q + 12'd1;
                rd_ptr_q   <= ~rd_ptr_q;
            end
            if (inflight_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_if_read) begin
                        state_q     <= S_RUN;
                        issue_cnt_q <= '0;
                        xfer_cnt_q  <= '0;
                    end
                end
                S_RUN: begin
                    if (xfer && (xfer_cnt_q == LAST_WORD)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            mem_q[wr_ptr_q] <= q_ifsram;
        end
    end

endmodule
